// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array and its edge feeder.
// Used by systolic_feeder and top_lvl so element widths and FSM encodings agree.
package systolic_pkg;

    localparam int DEFAULT_NUM_BITS = 8;
    localparam int DEFAULT_N        = 4;

    typedef logic [DEFAULT_NUM_BITS-1:0] elem_t;
    typedef elem_t [DEFAULT_N-1:0]       edge_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } feeder_state_e;

    // A full pass is N wavefront rows, N-1 extra skew steps, then N-1 drain steps.
    function automatic int stream_len(input int n);
        return 3 * n - 2;
    endfunction

    localparam int STREAM_LEN = 3 * DEFAULT_N - 2;

endpackage

// File: rtl/feeder_lane_sel.sv
// Skew select for one edge lane: presents element (t - lane) of the lane's
// stored vector while that index is in range, and zero otherwise.
module feeder_lane_sel #(
    parameter int NUM_BITS = 8,
    parameter int N        = 4,
    parameter int T_W      = 4,
    parameter int L_W      = 2
) (
    input  logic                         en,
    input  logic [L_W-1:0]               lane,
    input  logic [T_W-1:0]               t,
    input  logic [N-1:0][NUM_BITS-1:0]   elems,
    output logic [NUM_BITS-1:0]          elem
);

    int offset;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        elem   = '0;
        offset = int'(t) - int'(lane);
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (offset == k) begin
                    elem = elems[k];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Edge driver for the N x N output-stationary systolic array: buffers A and B,
// clears the accumulators, then streams skewed wavefronts. Optional build
// macro SYSTOLIC_FEEDER_B_ROWMAJOR_EN makes B loads row-major like A.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS,
    parameter int N        = DEFAULT_N
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ld_valid_i,
    output logic                           ld_ready_o,
    input  logic                           ld_sel_i,
    input  logic [$clog2(N)-1:0]           ld_idx_i,
    input  logic [N*NUM_BITS-1:0]          ld_data_i,
    input  logic                           start_i,
    output logic                           busy_o,
    output logic                           clr_o,
    output logic                           feed_valid_o,
    output logic [N-1:0][NUM_BITS-1:0]     west_o,
    output logic [N-1:0][NUM_BITS-1:0]     north_o,
    output logic                           done_o
);

    localparam int IDX_W = $clog2(N);
    localparam int LEN   = stream_len(N);
    localparam int T_W   = $clog2(LEN);

    typedef logic [N-1:0][NUM_BITS-1:0] row_t;

    feeder_state_e state_q, state_d;
    logic [T_W-1:0] t_q, t_d;

    row_t [N-1:0] a_buf;
    row_t [N-1:0] b_buf;
    row_t [N-1:0] b_col;
    row_t         west_d;
    row_t         north_d;

    logic ld_fire;
    logic stream_d;

    // ld_ready_o is high exactly in IDLE, so it doubles as the write enable gate.
    // Out-of-range indices are still handshaken but never written.
    assign ld_fire = ld_valid_i && ld_ready_o && (int'(ld_idx_i) < N);

    // NOTE: the buffers are architectural state that reset must clear, so they
    // sit under the synchronous reset like every other register here.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_buf <= '0;
            b_buf <= '0;
        end else if (ld_fire) begin
            if (!ld_sel_i) begin
                a_buf[ld_idx_i] <= ld_data_i;
            end else begin
`ifdef SYSTOLIC_FEEDER_B_ROWMAJOR_EN
                b_buf[ld_idx_i] <= ld_data_i;
`else
                for (int k = 0; k < N; k++) begin
                    b_buf[k][ld_idx_i] <= ld_data_i[k*NUM_BITS +: NUM_BITS];
                end
`endif
            end
        end
    end

    always_comb begin
        b_col = '0;
        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < N; k++) begin
                b_col[j][k] = b_buf[k][j];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = STREAM;
            end
            STREAM: begin
                t_d = t_q + 1'b1;
                if (t_q == T_W'(LEN - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Edges are selected from the next-cycle counter so the registered outputs
    // line up with the state they belong to.
    assign stream_d = (state_d == STREAM);

    for (genvar i = 0; i < N; i++) begin : g_lane
        feeder_lane_sel #(
            .NUM_BITS (NUM_BITS),
            .N        (N),
            .T_W      (T_W),
            .L_W      (IDX_W)
        ) u_west (
            .en    (stream_d),
            .lane  (IDX_W'(i)),
            .t     (t_d),
            .elems (a_buf[i]),
            .elem  (west_d[i])
        );

        feeder_lane_sel #(
            .NUM_BITS (NUM_BITS),
            .N        (N),
            .T_W      (T_W),
            .L_W      (IDX_W)
        ) u_north (
            .en    (stream_d),
            .lane  (IDX_W'(i)),
            .t     (t_d),
            .elems (b_col[i]),
            .elem  (north_d[i])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            t_q          <= '0;
            ld_ready_o   <= 1'b1;
            busy_o       <= 1'b0;
            clr_o        <= 1'b0;
            feed_valid_o <= 1'b0;
            done_o       <= 1'b0;
            west_o       <= '0;
            north_o      <= '0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            ld_ready_o   <= (state_d == IDLE);
            busy_o       <= (state_d != IDLE);
            clr_o        <= (state_d == CLEAR);
            feed_valid_o <= stream_d;
            done_o       <= (state_d == DONE);
            west_o       <= west_d;
            north_o      <= north_d;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (N = 4): a reference model of the
// buffers predicts every output frame of a pass into a scoreboard queue.
module tb_systolic_feeder;

    localparam int NB  = 8;
    localparam int N   = 4;
    localparam int LEN = 3 * N - 2;

    localparam int M_NORMAL = 0;
    localparam int M_BP     = 1;
    localparam int M_CO     = 2;
    localparam int M_XS     = 3;
    localparam int M_RST    = 4;

    typedef logic [N-1:0][NB-1:0] row_t;

    typedef struct packed {
        logic ld_ready;
        logic busy;
        logic clr;
        logic fv;
        logic done;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        row_t  west;
        row_t  north;
    } frame_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ld_valid_i;
    logic                 ld_ready_o;
    logic                 ld_sel_i;
    logic [1:0]           ld_idx_i;
    logic [N*NB-1:0]      ld_data_i;
    logic                 start_i;
    logic                 busy_o;
    logic                 clr_o;
    logic                 feed_valid_o;
    row_t                 west_o;
    row_t                 north_o;
    logic                 done_o;

    int     n_checks = 0;
    int     n_fail   = 0;
    frame_t sb[$];
    int     a_m[N][N];
    int     b_m[N][N];
    row_t   west_log[LEN];

    systolic_feeder #(.NUM_BITS(NB), .N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_valid_i   (ld_valid_i),
        .ld_ready_o   (ld_ready_o),
        .ld_sel_i     (ld_sel_i),
        .ld_idx_i     (ld_idx_i),
        .ld_data_i    (ld_data_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .clr_o        (clr_o),
        .feed_valid_o (feed_valid_o),
        .west_o       (west_o),
        .north_o      (north_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    function automatic ctrl_t cur_ctrl();
        ctrl_t c;
        c.ld_ready = ld_ready_o;
        c.busy     = busy_o;
        c.clr      = clr_o;
        c.fv       = feed_valid_o;
        c.done     = done_o;
        return c;
    endfunction

    function automatic void model_write(input logic sel, input int idx, input row_t row);
        for (int k = 0; k < N; k++) begin
            if (!sel) a_m[idx][k] = int'(row[k]);
`ifdef SYSTOLIC_FEEDER_B_ROWMAJOR_EN
            else      b_m[idx][k] = int'(row[k]);
`else
            else      b_m[k][idx] = int'(row[k]);
`endif
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                a_m[i][k] = 0;
                b_m[i][k] = 0;
            end
    endfunction

    // Frame k is the k-th cycle after the start edge: CLEAR, 3N-2 STREAM, DONE.
    function automatic frame_t exp_frame(input int k);
        frame_t f;
        int t;
        f = '0;
        f.ctrl.busy = 1'b1;
        if (k == 1) begin
            f.ctrl.clr = 1'b1;
        end else if (k == 3 * N) begin
            f.ctrl.done = 1'b1;
        end else begin
            f.ctrl.fv = 1'b1;
            t = k - 2;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) begin
                    f.west[i]  = NB'(a_m[i][t-i]);
                    f.north[i] = NB'(b_m[t-i][i]);
                end
            end
        end
        return f;
    endfunction

    task automatic load(input logic sel, input int idx, input row_t row);
        ld_valid_i = 1'b1;
        ld_sel_i   = sel;
        ld_idx_i   = 2'(idx);
        ld_data_i  = row;
        n_checks++;
        if (ld_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready idx=%0d got %b want 1", idx, ld_ready_o);
        end
        @(posedge clk);
        model_write(sel, idx, row);
        @(negedge clk);
        ld_valid_i = 1'b0;
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (cur_ctrl() !== ctrl_t'(5'b10000) || west_o !== '0 || north_o !== '0) begin
            n_fail++;
            $display("FAIL %s idle ctrl got %b want 10000, west %h north %h want 0",
                     name, cur_ctrl(), west_o, north_o);
        end
    endtask

    // Called at a negedge in IDLE. Runs one pass and compares every frame.
    task automatic run_pass(input string name, input int mode, input row_t co_row);
        frame_t f;
        int     done_cnt;
        start_i = 1'b1;
        if (mode == M_CO) begin
            ld_valid_i = 1'b1;
            ld_sel_i   = 1'b0;
            ld_idx_i   = 2'd0;
            ld_data_i  = co_row;
        end
        @(posedge clk);
        if (mode == M_CO) model_write(1'b0, 0, co_row);
        for (int k = 1; k <= 3 * N; k++) sb.push_back(exp_frame(k));
        done_cnt = 0;
        for (int k = 1; k <= 3 * N; k++) begin
            @(negedge clk);
            start_i    = 1'b0;
            if (mode == M_CO) ld_valid_i = 1'b0;
            if (mode == M_BP && k == 1) begin
                ld_valid_i = 1'b1;
                ld_sel_i   = 1'b0;
                ld_idx_i   = 2'd0;
                ld_data_i  = {N{8'd9}};
            end
            if (mode == M_XS && (k == 4 || k == 3 * N)) start_i = 1'b1;
            f = sb.pop_front();
            n_checks++;
            if (cur_ctrl() !== f.ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl k=%0d got %b want %b", name, k, cur_ctrl(), f.ctrl);
            end
            n_checks++;
            if (west_o !== f.west) begin
                n_fail++;
                $display("FAIL %s west k=%0d got %h want %h", name, k, west_o, f.west);
            end
            n_checks++;
            if (north_o !== f.north) begin
                n_fail++;
                $display("FAIL %s north k=%0d got %h want %h", name, k, north_o, f.north);
            end
            if (k >= 2 && k <= LEN + 1) west_log[k-2] = west_o;
            if (done_o === 1'b1) done_cnt++;
            if (mode == M_RST && k == 6) begin
                rst = 1'b1;
                break;
            end
        end
        if (mode == M_RST) begin
            sb.delete();
            @(negedge clk);
            rst = 1'b0;
            model_clear();
            check_idle({name, "_after_rst"});
            return;
        end
        @(negedge clk);
        start_i = 1'b0;
        check_idle(name);
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s done_count got %0d want 1", name, done_cnt);
        end
        if (mode == M_BP) begin
            @(posedge clk);
            model_write(1'b0, 0, {N{8'd9}});
            @(negedge clk);
            ld_valid_i = 1'b0;
        end
        if (mode == M_XS) begin
            @(negedge clk);
            n_checks++;
            if (clr_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s extra_clear clr=%b busy=%b want 0 0", name, clr_o, busy_o);
            end
        end
    endtask

    task automatic spot(input string name, input logic [NB-1:0] got, input logic [NB-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        ld_valid_i = 1'b0;
        ld_sel_i   = 1'b0;
        ld_idx_i   = '0;
        ld_data_i  = '0;
        start_i    = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
    endtask

    task automatic test_identity();
        row_t r;
        for (int i = 0; i < N; i++) begin
            r = '0;
            r[i] = 8'd1;
            load(1'b0, i, r);
            load(1'b1, i, r);
        end
        run_pass("identity", M_NORMAL, '0);
        spot("identity_t0_w0", west_log[0][0], 8'd1);
        spot("identity_t2_w1", west_log[2][1], 8'd1);
        spot("identity_t6_w3", west_log[6][3], 8'd1);
    endtask

    task automatic test_general_skew();
        row_t r;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) r[k] = NB'(4 * i + k + 1);
            load(1'b0, i, r);
            for (int k = 0; k < N; k++) r[k] = NB'(4 * k + i + 1);
`ifdef SYSTOLIC_FEEDER_B_ROWMAJOR_EN
            for (int k = 0; k < N; k++) r[k] = NB'(4 * i + k + 1);
`endif
            load(1'b1, i, r);
        end
        run_pass("skew", M_NORMAL, '0);
        n_checks++;
        if (west_log[3] !== {8'd13, 8'd10, 8'd7, 8'd4}) begin
            n_fail++;
            $display("FAIL skew_t3 got %h want 0d0a0704", west_log[3]);
        end
        n_checks++;
        if (west_log[6] !== {8'd16, 8'd0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL skew_t6 got %h want 10000000", west_log[6]);
        end
    endtask

    task automatic test_backpressure();
        run_pass("backpressure", M_BP, '0);
        run_pass("bp_next_pass", M_NORMAL, '0);
        spot("bp_t0_w0", west_log[0][0], 8'd9);
    endtask

    task automatic test_load_start_same_cycle();
        run_pass("co_load", M_CO, {N{8'd5}});
        spot("co_load_t0_w0", west_log[0][0], 8'd5);
    endtask

    task automatic test_start_ignored();
        run_pass("start_ignored", M_XS, '0);
    endtask

    task automatic test_reset_mid_stream();
        run_pass("mid_rst", M_RST, '0);
        run_pass("after_rst_zero", M_NORMAL, '0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_general_skew();
        test_backpressure();
        test_load_start_same_cycle();
        test_start_ignored();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
